// File: rtl/ir_frame_transmitter.sv
// ---------------------------------------------------------------------------
// ir_frame_transmitter
//
// Transmit side of the 32-bit IR link. Serialises one 32-bit word into a
// pulse-distance frame:
//   leader mark (16 units) and leader space (8 units),
//   32 data bits sent LSB first (1-unit mark, then a 1-unit space for a 0
//   or a 3-unit space for a 1),
//   stop mark (1 unit).
// All outputs are registered. ir_out is the envelope, optionally gated by a
// square-wave carrier that restarts high at the start of every mark.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   tx_data      word to transmit, latched on accept
//   tx_valid     tx_data is valid
//   tx_ready     block can accept a word (only in IDLE)
//   ir_out       IR LED drive (envelope AND carrier when CARRIER_EN=1)
//   ir_envelope  unmodulated mark/space envelope (1 = mark)
//   busy         a frame is in progress
//   bit_count    number of data bits fully sent, 0..32
//   done         one-cycle pulse in the first IDLE cycle after a frame
// ---------------------------------------------------------------------------
module ir_frame_transmitter #(
  parameter int unsigned UNIT_CYCLES  = 28125,  // cycles per timing unit, >= 2
  parameter int unsigned CARRIER_HALF = 658,    // cycles per carrier half-period, >= 1
  parameter bit          CARRIER_EN   = 1'b1    // 1: modulate ir_out with the carrier
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        ir_out,
  output logic        ir_envelope,
  output logic        busy,
  output logic [5:0]  bit_count,
  output logic        done
);

  localparam int unsigned TIMER_W   = $clog2(16 * UNIT_CYCLES) + 1;
  localparam int unsigned CARRIER_W = $clog2(CARRIER_HALF) + 1;

  // The phase timer counts down to zero, so each phase loads its length - 1.
  localparam logic [TIMER_W-1:0] LEAD_MARK_LAST  = TIMER_W'(16 * UNIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LEAD_SPACE_LAST = TIMER_W'(8 * UNIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] UNIT_LAST       = TIMER_W'(UNIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] ONE_SPACE_LAST  = TIMER_W'(3 * UNIT_CYCLES - 1);
  localparam logic [CARRIER_W-1:0] CARRIER_LAST  = CARRIER_W'(CARRIER_HALF - 1);

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK
  } state_t;

  state_t               state;
  logic [31:0]          shift_reg;
  logic [TIMER_W-1:0]   phase_timer;
  logic [CARRIER_W-1:0] carrier_cnt;
  logic                 carrier;

  wire phase_end = (phase_timer == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      shift_reg   <= '0;
      phase_timer <= '0;
      carrier_cnt <= '0;
      carrier     <= 1'b0;
      ir_envelope <= 1'b0;
      ir_out      <= 1'b0;
      busy        <= 1'b0;
      tx_ready    <= 1'b1;
      bit_count   <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;

      // Carrier advance inside a mark. The phase-change branches below assign
      // carrier/ir_out again on mark or space entry.
      // NOTE: with non-blocking assignments the last one executed in the block
      // wins, so entry values below override this default advance cleanly.
      if (ir_envelope) begin
        if (carrier_cnt == '0) begin
          carrier     <= ~carrier;
          carrier_cnt <= CARRIER_LAST;
          ir_out      <= CARRIER_EN ? ~carrier : 1'b1;
        end else begin
          carrier_cnt <= carrier_cnt - CARRIER_W'(1);
        end
      end

      if (state != IDLE && !phase_end) begin
        phase_timer <= phase_timer - TIMER_W'(1);
      end

      unique case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            shift_reg   <= tx_data;
            bit_count   <= '0;
            state       <= LEAD_MARK;
            phase_timer <= LEAD_MARK_LAST;
            busy        <= 1'b1;
            tx_ready    <= 1'b0;
            // mark entry: carrier restarts high
            ir_envelope <= 1'b1;
            carrier     <= 1'b1;
            carrier_cnt <= CARRIER_LAST;
            ir_out      <= 1'b1;
          end
        end

        LEAD_MARK: begin
          if (phase_end) begin
            state       <= LEAD_SPACE;
            phase_timer <= LEAD_SPACE_LAST;
            ir_envelope <= 1'b0;
            carrier     <= 1'b0;
            ir_out      <= 1'b0;
          end
        end

        LEAD_SPACE: begin
          if (phase_end) begin
            state       <= BIT_MARK;
            phase_timer <= UNIT_LAST;
            ir_envelope <= 1'b1;
            carrier     <= 1'b1;
            carrier_cnt <= CARRIER_LAST;
            ir_out      <= 1'b1;
          end
        end

        BIT_MARK: begin
          if (phase_end) begin
            state       <= BIT_SPACE;
            // pulse-distance coding: the space length carries the bit value
            phase_timer <= shift_reg[0] ? ONE_SPACE_LAST : UNIT_LAST;
            ir_envelope <= 1'b0;
            carrier     <= 1'b0;
            ir_out      <= 1'b0;
          end
        end

        BIT_SPACE: begin
          if (phase_end) begin
            shift_reg   <= {1'b0, shift_reg[31:1]};
            bit_count   <= bit_count + 6'd1;
            // bit_count still holds the pre-increment value here
            state       <= (bit_count == 6'd31) ? STOP_MARK : BIT_MARK;
            phase_timer <= UNIT_LAST;
            ir_envelope <= 1'b1;
            carrier     <= 1'b1;
            carrier_cnt <= CARRIER_LAST;
            ir_out      <= 1'b1;
          end
        end

        STOP_MARK: begin
          if (phase_end) begin
            state       <= IDLE;
            busy        <= 1'b0;
            tx_ready    <= 1'b1;
            done        <= 1'b1;
            ir_envelope <= 1'b0;
            carrier     <= 1'b0;
            ir_out      <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ir_frame_transmitter.sv
// ---------------------------------------------------------------------------
// Testbench for ir_frame_transmitter with UNIT_CYCLES=4, CARRIER_HALF=1.
// Two instances share clk/reset/tx_data: dut0 has CARRIER_EN=0, dut1 has
// CARRIER_EN=1. 'sel' chooses which one receives tx_valid and is observed.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_ir_frame_transmitter;

  localparam int UNIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        sel;

  always #5 clk = ~clk;

  logic       tx_valid0, tx_ready0, ir_out0, env0, busy0, done0;
  logic       tx_valid1, tx_ready1, ir_out1, env1, busy1, done1;
  logic [5:0] bit_count0, bit_count1;

  assign tx_valid0 = tx_valid & ~sel;
  assign tx_valid1 = tx_valid & sel;

  ir_frame_transmitter #(.UNIT_CYCLES(UNIT), .CARRIER_HALF(1), .CARRIER_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid0),
    .tx_ready(tx_ready0), .ir_out(ir_out0), .ir_envelope(env0), .busy(busy0),
    .bit_count(bit_count0), .done(done0)
  );

  ir_frame_transmitter #(.UNIT_CYCLES(UNIT), .CARRIER_HALF(1), .CARRIER_EN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid1),
    .tx_ready(tx_ready1), .ir_out(ir_out1), .ir_envelope(env1), .busy(busy1),
    .bit_count(bit_count1), .done(done1)
  );

  logic       o_ready, o_out, o_env, o_busy, o_done;
  logic [5:0] o_bits;
  assign o_ready = sel ? tx_ready1  : tx_ready0;
  assign o_out   = sel ? ir_out1    : ir_out0;
  assign o_env   = sel ? env1       : env0;
  assign o_busy  = sel ? busy1      : busy0;
  assign o_done  = sel ? done1      : done0;
  assign o_bits  = sel ? bit_count1 : bit_count0;

  int tests_run    = 0;
  int tests_failed = 0;

  int exp_runs[$];
  int meas_runs[$];
  int meas_busy, meas_done_in_frame, meas_out_err, meas_excl_err;
  logic meas_done_end;
  bit meas_timeout;

  // Expected envelope run lengths (alternating mark/space) for one frame.
  task automatic build_expected(input logic [31:0] d);
    exp_runs.delete();
    exp_runs.push_back(16 * UNIT);
    exp_runs.push_back(8 * UNIT);
    for (int i = 0; i < 32; i++) begin
      exp_runs.push_back(UNIT);
      exp_runs.push_back(d[i] ? 3 * UNIT : UNIT);
    end
    exp_runs.push_back(UNIT);
  endtask

  // Starts at the first negedge after the accept edge, returns at the negedge
  // of the first non-busy cycle (the done cycle).
  task automatic measure_frame();
    int   cur_len;
    logic cur_lvl;
    int   mark_pos;
    logic exp_o;
    meas_runs.delete();
    meas_busy = 0; meas_done_in_frame = 0; meas_out_err = 0; meas_excl_err = 0;
    meas_done_end = 1'b0; meas_timeout = 1'b1;
    cur_len = 0; cur_lvl = o_env; mark_pos = 0;
    for (int c = 0; c < 3000; c++) begin
      if (o_ready && o_busy) meas_excl_err++;
      if (!o_busy) begin
        if (cur_len > 0) meas_runs.push_back(cur_len);
        meas_done_end = o_done;
        meas_timeout  = 1'b0;
        break;
      end
      meas_busy++;
      if (o_done) meas_done_in_frame++;
      if (o_env !== cur_lvl) begin
        meas_runs.push_back(cur_len);
        cur_len  = 0;
        cur_lvl  = o_env;
        mark_pos = 0;
      end
      cur_len++;
      // carrier with half-period 1: high on the first mark cycle, then toggles
      exp_o = o_env ? (sel ? ((mark_pos % 2) == 0) : 1'b1) : 1'b0;
      if (o_out !== exp_o) meas_out_err++;
      if (o_env) mark_pos++;
      @(negedge clk);
    end
  endtask

  task automatic check_frame(input string name, input logic [31:0] d);
    int exp_busy;
    int bad;
    build_expected(d);
    measure_frame();
    tests_run++;
    if (meas_timeout) begin
      tests_failed++;
      $display("FAIL %s timeout: busy never dropped within 3000 cycles (required frame end)", name);
      return;
    end
    exp_busy = 0;
    foreach (exp_runs[i]) exp_busy += exp_runs[i];

    tests_run++;
    if (meas_busy !== exp_busy) begin
      tests_failed++;
      $display("FAIL %s busy_cycles: got %0d, expected %0d", name, meas_busy, exp_busy);
    end

    bad = -1;
    if (meas_runs.size() != exp_runs.size()) bad = -2;
    else foreach (exp_runs[i]) if (bad < 0 && meas_runs[i] != exp_runs[i]) bad = i;
    tests_run++;
    if (bad == -2) begin
      tests_failed++;
      $display("FAIL %s run_count: got %0d runs, expected %0d", name, meas_runs.size(), exp_runs.size());
    end else if (bad >= 0) begin
      tests_failed++;
      $display("FAIL %s run[%0d]: got %0d cycles, expected %0d", name, bad, meas_runs[bad], exp_runs[bad]);
    end

    tests_run++;
    if (meas_done_end !== 1'b1 || meas_done_in_frame !== 0) begin
      tests_failed++;
      $display("FAIL %s done: end=%b during_frame=%0d, expected end=1 during_frame=0",
               name, meas_done_end, meas_done_in_frame);
    end

    tests_run++;
    if (meas_out_err !== 0) begin
      tests_failed++;
      $display("FAIL %s ir_out_pattern: %0d bad cycles, expected 0", name, meas_out_err);
    end

    tests_run++;
    if (meas_excl_err !== 0) begin
      tests_failed++;
      $display("FAIL %s busy_ready_excl: %0d overlapping cycles, expected 0", name, meas_excl_err);
    end

    tests_run++;
    if (o_bits !== 6'd32 || o_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s end_state: bit_count=%0d tx_ready=%b, expected 32 and 1", name, o_bits, o_ready);
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      tests_run++;
      if ({o_out, o_env, o_busy, o_ready, o_bits, o_done} !== {4'b0001, 6'd0, 1'b0}) begin
        tests_failed++;
        $display("FAIL reset_idle cycle %0d: out=%b env=%b busy=%b ready=%b bits=%0d done=%b, expected 0 0 0 1 0 0",
                 c, o_out, o_env, o_busy, o_ready, o_bits, o_done);
      end
    end
  endtask

  task automatic start_frame(input logic [31:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic test_zero_frame();
    start_frame(32'h0000_0000);
    check_frame("zero", 32'h0000_0000);
    @(negedge clk);
    tests_run++;
    if (o_done !== 1'b0 || o_bits !== 6'd32 || o_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL zero_after_done: done=%b bits=%0d ready=%b, expected 0 32 1", o_done, o_bits, o_ready);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    tx_data  = 32'hFFFF_FFFF;
    tx_valid = 1'b1;
    @(negedge clk);
    // tx_valid stays high for the whole first frame
    check_frame("ones", 32'hFFFF_FFFF);
    tx_data = 32'h0000_0001;
    @(negedge clk);
    tx_valid = 1'b0;
    tests_run++;
    if (o_env !== 1'b1 || o_busy !== 1'b1 || o_bits !== 6'd0) begin
      tests_failed++;
      $display("FAIL b2b_start: env=%b busy=%b bits=%0d, expected 1 1 0", o_env, o_busy, o_bits);
    end
    check_frame("b2b", 32'h0000_0001);
  endtask

  task automatic test_carrier();
    logic [31:0] decoded;
    sel = 1'b1;
    start_frame(32'hA5A5_A5A5);
    check_frame("carrier", 32'hA5A5_A5A5);
    decoded = '0;
    if (meas_runs.size() == 67)
      for (int i = 0; i < 32; i++) decoded[i] = (meas_runs[3 + 2 * i] > 2 * UNIT);
    tests_run++;
    if (meas_runs.size() != 67 || decoded !== 32'hA5A5_A5A5) begin
      tests_failed++;
      $display("FAIL carrier_decode: got %h (%0d runs), expected a5a5a5a5", decoded, meas_runs.size());
    end
    @(negedge clk);
    sel = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    bit reached;
    int bad_idle;
    start_frame(32'h0F0F_0F0F);
    reached = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (o_bits == 6'd10) begin
        reached = 1'b1;
        break;
      end
      @(negedge clk);
    end
    tests_run++;
    if (!reached) begin
      tests_failed++;
      $display("FAIL midreset_reach: bit_count=%0d, expected to reach 10", o_bits);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests_run++;
    if ({o_out, o_env, o_busy, o_ready, o_bits, o_done} !== {4'b0001, 6'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL midreset_state: out=%b env=%b busy=%b ready=%b bits=%0d done=%b, expected 0 0 0 1 0 0",
               o_out, o_env, o_busy, o_ready, o_bits, o_done);
    end
    bad_idle = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (o_done !== 1'b0 || o_busy !== 1'b0 || o_env !== 1'b0) bad_idle++;
    end
    tests_run++;
    if (bad_idle !== 0) begin
      tests_failed++;
      $display("FAIL midreset_no_done: %0d cycles with done/busy/env set, expected 0", bad_idle);
    end
    start_frame(32'h1234_5678);
    check_frame("after_reset", 32'h1234_5678);
  endtask

  initial begin
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    sel      = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    test_reset();
    test_zero_frame();
    test_back_to_back();
    test_carrier();
    test_reset_mid_frame();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ir_frame_transmitter.md
Name: ir_frame_transmitter

Overview:
- Transmit side of the team's 32-bit IR link: serialises one 32-bit word into a pulse-distance IR frame of the NEC style.
- Frame is a leader mark, a leader space, 32 data bits sent LSB first, then a stop mark.
- Drives the IR LED path with an optionally carrier-modulated output.
- Emits a one-cycle done pulse once all 32 bits have been sent, mirroring the receive-side 32-bit counter's completion point.

Parameters:
- UNIT_CYCLES, 28125: clock cycles per timing unit (562.5 us at 50 MHz); must be >= 2.
- CARRIER_HALF, 658: clock cycles per carrier half-period (~38 kHz at 50 MHz); must be >= 1.
- CARRIER_EN, 1: 1 means ir_out = envelope AND carrier; 0 means ir_out = envelope.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- tx_data  input  32  word to transmit; sampled only on accept.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  block can accept a word.
- ir_out  output  1  drive to the IR LED, modulated per CARRIER_EN.
- ir_envelope  output  1  unmodulated mark/space envelope (1 = mark).
- busy  output  1  a frame is in progress.
- bit_count  output  6  number of data bits fully sent, 0..32.
- done  output  1  one-cycle pulse at frame end.

Behaviour:
- Reset:
  - Applies on the clk edge where reset=1.
  - State goes to IDLE; shift register, phase timer and carrier counter are cleared.
  - After reset: ir_out=0, ir_envelope=0, busy=0, done=0, bit_count=0, tx_ready=1.
  - Reset mid-frame aborts the frame immediately. There is no stop mark and no done pulse.
- Handshake:
  - Accept occurs on an edge where tx_valid=1 and tx_ready=1.
  - tx_ready=1 only in IDLE.
  - tx_valid while busy is ignored; no queuing.
  - On accept: tx_data is latched into the shift register, bit_count is cleared, and the state goes to LEAD_MARK.
- States and durations (exact cycle counts; the phase timer reloads on each entry):
  - IDLE: envelope 0. Leaves on accept.
  - LEAD_MARK: 16*UNIT_CYCLES cycles, envelope 1, then LEAD_SPACE.
  - LEAD_SPACE: 8*UNIT_CYCLES cycles, envelope 0, then BIT_MARK.
  - BIT_MARK: 1*UNIT_CYCLES cycles, envelope 1, then BIT_SPACE.
  - BIT_SPACE: 1*UNIT_CYCLES cycles if the current bit (shift_reg[0]) is 0, 3*UNIT_CYCLES cycles if it is 1; envelope 0.
    - On exit: shift right by 1 and bit_count += 1.
    - Next state is BIT_MARK if the new bit_count < 32, else STOP_MARK.
  - STOP_MARK: 1*UNIT_CYCLES cycles, envelope 1, then IDLE. done=1 for exactly the first IDLE cycle.
- Frame length:
  - 89 units plus 2 units per 1-bit.
  - 0x00000000 gives 89 units; 0xFFFFFFFF gives 153 units.
- Latency:
  - ir_envelope rises in the first cycle after the accept edge.
  - busy=1 from the cycle after accept through the last STOP_MARK cycle.
  - busy and tx_ready are mutually exclusive at all times.
- Back-to-back frames:
  - tx_ready=1 during the done cycle.
  - An accept on the edge ending the done cycle starts LEAD_MARK on the next cycle.
  - The minimum gap between frames is therefore 1 cycle of envelope 0.
- bit_count:
  - Holds 32 through STOP_MARK and IDLE until the next accept.
  - Never exceeds 32 and never wraps.
- Carrier:
  - Counter resets at every mark entry with carrier=1.
  - Toggles every CARRIER_HALF cycles while in a mark.
  - Forced to 0 in spaces and in IDLE.
- ir_out:
  - Registered, and aligned cycle-for-cycle with ir_envelope.
  - Never 1 while ir_envelope=0.
- Arithmetic:
  - Phase timer width is clog2(16*UNIT_CYCLES)+1.
  - All counters are unsigned with no overflow in legal use.

Test Plan:
- Setup for all scenarios: UNIT_CYCLES=4, CARRIER_HALF=1, CARRIER_EN=0.
- Reset then idle → ir_out=0, busy=0, tx_ready=1, bit_count=0, done=0 for 20 cycles; no accept occurs with tx_valid=0.
- Send 0x00000000 → envelope high 64 cycles, low 32, then 32×(high 4, low 4), then stop high 4. busy=1 for 356 cycles; done pulses once; bit_count=32.
- Send 0xFFFFFFFF, then 0x00000001 → frame 1 is 612 busy cycles with every bit space 12 cycles. Frame 2 has its first bit space 12 cycles and the rest 4. tx_valid held high during frame 1 is not re-accepted; frame 2 starts 1 cycle after done.
- Send 0xA5A5A5A5 with CARRIER_EN=1 → measured space lengths decode LSB-first back to 0xA5A5A5A5. ir_out toggles every cycle inside marks, starts at 1 on each mark, and is 0 in spaces.
- Assert reset while bit_count=10 → next cycle all outputs are at reset values with no done pulse. A new 0x12345678 frame then completes normally with bit_count=32.
